// File: rtl/cache_mem_arbiter.sv
// Arbitrates one wishbone-style memory port between icache and dcache miss ports.
// Grant registered (request->mem_stb 1 cycle), ack combinational, one dead cycle between grants.
`timescale 1ns/1ps

module cache_mem_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 128,
    parameter int SEL_W      = 16,
    parameter int FIXED_PRIO = 0,
    parameter int WDOG_MAX   = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_stb,
    input  logic [ADDR_W-1:0] i_adr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_dat_s,
    input  logic              d_stb,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_adr,
    input  logic [DATA_W-1:0] d_dat_m,
    input  logic [SEL_W-1:0]  d_sel,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_dat_s,
    output logic              mem_cyc,
    output logic              mem_stb,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_adr,
    output logic [DATA_W-1:0] mem_dat_m,
    output logic [SEL_W-1:0]  mem_sel,
    input  logic              mem_ack,
    input  logic              mem_rty,
    input  logic [DATA_W-1:0] mem_dat_s,
    output logic              wdog_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2
    } state_t;

    localparam logic [15:0] WDOG_LIM = 16'(WDOG_MAX);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [15:0] wdog_cnt_q, wdog_cnt_d;
    logic        wdog_err_q, wdog_err_d;

    logic gnt_i, gnt_d, live, ack_live, pick_d;

    // A grant only drives the bus while its owner still holds stb, so an abort
    // drops mem_stb in the same cycle and any coincident mem_ack is lost.
    always_comb begin
        gnt_i    = (state_q == GNT_I);
        gnt_d    = (state_q == GNT_D);
        live     = (gnt_i && i_stb) || (gnt_d && d_stb);
        ack_live = live && mem_ack;
    end

    assign mem_stb  = live;
    assign mem_cyc  = live;
    assign i_ack    = gnt_i && i_stb && mem_ack;
    assign d_ack    = gnt_d && d_stb && mem_ack;
    assign i_dat_s  = mem_dat_s;
    assign d_dat_s  = mem_dat_s;
    assign wdog_err = wdog_err_q;

    always_comb begin
        mem_we    = 1'b0;
        mem_adr   = '0;
        mem_dat_m = '0;
        mem_sel   = '0;
        if (gnt_i && i_stb) begin
            mem_adr = i_adr;
            mem_sel = '1;
        end else if (gnt_d && d_stb) begin
            mem_we    = d_we;
            mem_adr   = d_adr;
            mem_dat_m = d_dat_m;
            mem_sel   = d_sel;
        end
    end

    always_comb begin
        state_d    = state_q;
        last_d_d   = last_d_q;
        wdog_cnt_d = wdog_cnt_q;
        wdog_err_d = wdog_err_q;

        if (i_stb && d_stb) begin
            pick_d = (FIXED_PRIO != 0) ? 1'b1 : !last_d_q;
        end else begin
            pick_d = d_stb;
        end

        case (state_q)
            IDLE: begin
                if (i_stb || d_stb) begin
                    state_d    = pick_d ? GNT_D : GNT_I;
                    last_d_d   = pick_d;
                    wdog_cnt_d = '0;
                end
            end
            GNT_I, GNT_D: begin
                if (!ack_live && (wdog_cnt_q != WDOG_LIM)) begin
                    wdog_cnt_d = wdog_cnt_q + 16'd1;
                end
                if (wdog_cnt_d == WDOG_LIM) begin
                    wdog_err_d = 1'b1;
                end
                // Ack has priority over retry; both, or an abort, release the port.
                if (!live || mem_ack || mem_rty) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b1;
            wdog_cnt_q <= '0;
            wdog_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            wdog_cnt_q <= wdog_cnt_d;
            wdog_err_q <= wdog_err_d;
        end
    end

endmodule
